// File: rtl/key_pulse_bank.sv
// key_pulse_bank
//   N independent key channels. Each channel synchronises its raw key level,
//   debounces press and release, emits a one-cycle pulse per accepted press and,
//   optionally, auto-repeat pulses while the key stays held.
// Ports
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous, active-high reset
//   in     in   N  raw asynchronous key levels, 1 = pressed
//   pulse  out  N  one-cycle press/repeat pulse, low-true when OUT_ACTIVE_LOW
//   held   out  N  1 while the channel is in an accepted-pressed state

module key_pulse_bank_lane #(
  parameter int DEBOUNCE       = 4,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_RATE    = 8,
  parameter bit OUT_ACTIVE_LOW = 1'b1,
  parameter int DCW            = 3,
  parameter int RCW            = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse,
  output logic held
);
  typedef enum logic [2:0] {IDLE, ARMING, FIRE, HOLD, REPEAT, RELEASING} state_t;

  // Thresholds compare against the counter value *before* increment, hence -1 / -2.
  localparam int RD_TH_I = (REPEAT_DELAY >= 2) ? REPEAT_DELAY - 2 : 0;
  localparam int RR_TH_I = (REPEAT_RATE  >= 2) ? REPEAT_RATE  - 2 : 0;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE - 1);
  localparam logic [RCW-1:0] RD_TH   = RCW'(RD_TH_I);
  localparam logic [RCW-1:0] RR_TH   = RCW'(RR_TH_I);

  logic           q1, q2;
  state_t         st, st_n;
  logic [DCW-1:0] dc, dc_n;
  logic [RCW-1:0] rc, rc_n;
  logic           rep, rep_n;
  logic [RCW-1:0] th;

  always_ff @(posedge clk) begin
    if (reset) begin
      q1  <= 1'b0;
      q2  <= 1'b0;
      st  <= IDLE;
      dc  <= '0;
      rc  <= '0;
      rep <= 1'b0;
    end else begin
      q1  <= key;
      q2  <= q1;
      st  <= st_n;
      dc  <= dc_n;
      rc  <= rc_n;
      rep <= rep_n;
    end
  end

  assign th = (st == REPEAT) ? RR_TH : RD_TH;

  always_comb begin
    st_n  = st;
    dc_n  = dc;
    rc_n  = rc;
    rep_n = rep;
    case (st)
      IDLE: begin
        if (q2) begin
          if (DEBOUNCE == 1) st_n = FIRE;
          else begin
            st_n = ARMING;
            dc_n = DCW'(1);
          end
        end
      end
      ARMING: begin
        if (!q2) begin
          st_n = IDLE;
          dc_n = '0;
        end else if (dc == DB_LAST) begin
          st_n = FIRE;
          dc_n = '0;
        end else begin
          dc_n = dc + 1'b1;
        end
      end
      FIRE: begin
        st_n = rep ? REPEAT : HOLD;
        rc_n = '0;
      end
      HOLD, REPEAT: begin
        if (!q2) begin
          if (DEBOUNCE == 1) begin
            st_n  = IDLE;
            rep_n = 1'b0;
          end else begin
            st_n = RELEASING;
            dc_n = DCW'(1);
          end
        end else if (REPEAT_DELAY != 0 && rc == th) begin
          st_n  = FIRE;
          rep_n = 1'b1;
        end else if (rc != '1) begin
          // Saturate so a repeat-off hold can sit forever without wrapping.
          rc_n = rc + 1'b1;
        end
      end
      RELEASING: begin
        if (q2) begin
          // Release bounce: back to held, repeat timing restarts from the first delay.
          st_n  = HOLD;
          rc_n  = '0;
          rep_n = 1'b0;
          dc_n  = '0;
        end else if (dc == DB_LAST) begin
          st_n  = IDLE;
          rep_n = 1'b0;
          dc_n  = '0;
        end else begin
          dc_n = dc + 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Decoded from registered state only: no path from key to the outputs.
  assign pulse = (st == FIRE) ^ OUT_ACTIVE_LOW;
  assign held  = (st == FIRE) || (st == HOLD) || (st == REPEAT) || (st == RELEASING);
endmodule

module key_pulse_bank #(
  parameter int N              = 4,
  parameter int DEBOUNCE       = 4,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_RATE    = 8,
  parameter bit OUT_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic [N-1:0] pulse,
  output logic [N-1:0] held
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DCW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int RCW  = $clog2(RMAX + 1);

  for (genvar i = 0; i < N; i++) begin : g_lane
    key_pulse_bank_lane #(
      .DEBOUNCE      (DEBOUNCE),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE),
      .OUT_ACTIVE_LOW(OUT_ACTIVE_LOW),
      .DCW           (DCW),
      .RCW           (RCW)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .key  (in[i]),
      .pulse(pulse[i]),
      .held (held[i])
    );
  end
endmodule

// File: tb/tb_key_pulse_bank.sv
// tb_key_pulse_bank
//   Directed bench for key_pulse_bank at N=4, DEBOUNCE=4, REPEAT_DELAY=16,
//   REPEAT_RATE=8, active-low pulse. Edge e is the e-th rising edge of a scenario;
//   inputs are set before edge e and outputs sampled 1 time unit after it.

module tb_key_pulse_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in;
  logic [3:0] pulse;
  logic [3:0] held;
  int         total = 0;
  int         bad   = 0;

  key_pulse_bank #(
    .N(4), .DEBOUNCE(4), .REPEAT_DELAY(16), .REPEAT_RATE(8), .OUT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .pulse(pulse),
    .held (held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int e, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s edge %0d: got %h want %h", tag, e, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in    = 4'h0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] ep, eh;
    reset = 1'b1;
    in    = 4'h0;
    tick();
    chk("reset pulse", 0, pulse, 4'hF);
    chk("reset held", 0, held, 4'h0);
    tick();
    reset = 1'b0;

    // 1: clean press on ch0, released after edge 11
    for (int e = 0; e <= 24; e++) begin
      in = (e <= 11) ? 4'b0001 : 4'b0000;
      tick();
      ep = (e == 5) ? 4'hE : 4'hF;
      eh = (e >= 5 && e <= 16) ? 4'b0001 : 4'b0000;
      chk("t1 pulse", e, pulse, ep);
      chk("t1 held", e, held, eh);
    end
    do_reset();

    // 2: ch1 bounces 1,0,1,0 then stays high
    for (int e = 0; e <= 20; e++) begin
      in = (e < 4) ? ((e % 2 == 0) ? 4'b0010 : 4'b0000) : 4'b0010;
      tick();
      ep = (e == 9) ? 4'hD : 4'hF;
      eh = (e >= 9) ? 4'b0010 : 4'b0000;
      chk("t2 pulse", e, pulse, ep);
      chk("t2 held", e, held, eh);
    end
    do_reset();

    // 3: ch2 held for 50 edges, auto-repeat
    for (int e = 0; e <= 58; e++) begin
      in = (e <= 49) ? 4'b0100 : 4'b0000;
      tick();
      ep = (e == 5 || e == 21 || e == 29 || e == 37 || e == 45) ? 4'hB : 4'hF;
      eh = (e >= 5 && e <= 54) ? 4'b0100 : 4'b0000;
      chk("t3 pulse", e, pulse, ep);
      chk("t3 held", e, held, eh);
    end
    do_reset();

    // 4: ch3 release bounce of 2 samples restarts the first-delay timing
    for (int e = 0; e <= 32; e++) begin
      in = (e == 10 || e == 11) ? 4'b0000 : 4'b1000;
      tick();
      ep = (e == 5 || e == 29) ? 4'h7 : 4'hF;
      eh = (e >= 5) ? 4'b1000 : 4'b0000;
      chk("t4 pulse", e, pulse, ep);
      chk("t4 held", e, held, eh);
    end
    do_reset();

    // 5: reset while ch0 is held; key must re-debounce afterwards
    for (int e = 0; e <= 20; e++) begin
      in    = 4'b0001;
      reset = (e == 10);
      tick();
      ep = (e == 5 || e == 16) ? 4'hE : 4'hF;
      eh = ((e >= 5 && e <= 9) || e >= 16) ? 4'b0001 : 4'b0000;
      chk("t5 pulse", e, pulse, ep);
      chk("t5 held", e, held, eh);
    end
    reset = 1'b0;
    do_reset();

    // 6: all rise together, ch1 drops from edge 8; others keep repeat timing
    for (int e = 0; e <= 30; e++) begin
      in = (e >= 8) ? 4'b1101 : 4'b1111;
      tick();
      if (e == 5) ep = 4'h0;
      else if (e == 21 || e == 29) ep = 4'b0010;
      else ep = 4'hF;
      if (e < 5) eh = 4'h0;
      else if (e <= 12) eh = 4'hF;
      else eh = 4'b1101;
      chk("t6 pulse", e, pulse, ep);
      chk("t6 held", e, held, eh);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
